// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and constants for the serial-to-parallel parity receiver
package s2p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/s2p_parity_rx_if.sv
// rtl/s2p_parity_rx_if.sv - serial input / parallel output bundle (err_count under S2P_ERR_CNT_EN)
import s2p_pkg::*;

interface s2p_parity_rx_if #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              sin;
  logic              sin_valid;
  logic              sof;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              busy;
`ifdef S2P_ERR_CNT_EN
  logic [7:0]        err_count;
`endif

  modport master (
    output sin, sin_valid, sof,
    input  data_out, data_valid, parity_err, busy
`ifdef S2P_ERR_CNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  sin, sin_valid, sof,
    output data_out, data_valid, parity_err, busy
`ifdef S2P_ERR_CNT_EN
    , output err_count
`endif
  );

endinterface

// File: rtl/s2p_parity_rx_parity_calc.sv
// rtl/s2p_parity_rx_parity_calc.sv - XOR-reduction parity with even/odd select, shared with the transmitter
import s2p_pkg::*;

module parity_calc #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  // Even mode: parity is the XOR of the data; odd mode inverts it.
  assign par = (^data) ^ PARITY_ODD;

endmodule

// File: rtl/s2p_parity_rx.sv
// rtl/s2p_parity_rx.sv - serial-to-parallel receiver with parity check (optional err_count via S2P_ERR_CNT_EN)
import s2p_pkg::*;

module s2p_parity_rx #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic            clk,
  input  logic            reset,
  s2p_parity_rx_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              exp_par;
  logic              start;
  logic              last_bit;
  logic              par_take;

  parity_calc #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity_calc (
    .data (shreg),
    .par  (exp_par)
  );

  // Qualified strobes: a valid sof restarts from any state; the parity bit is accepted only without sof.
  always_comb begin
    start    = bus.sin_valid & bus.sof;
    last_bit = (cnt == CNT_W'(DATA_W - 1));
    par_take = (state == PARITY) & bus.sin_valid & ~bus.sof;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a valid sof always (re)starts a frame, which also covers back-to-back from DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (start)                          state_nxt = SHIFT;
        else if (bus.sin_valid && last_bit) state_nxt = PARITY;
      end
      PARITY: begin
        if (start)              state_nxt = SHIFT;
        else if (bus.sin_valid) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and registered result; data_out survives aborts, only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      if (start) begin
        shreg <= {bus.sin, shreg[DATA_W-1:1]};
        cnt   <= CNT_W'(1);
      end else if (state == SHIFT && bus.sin_valid) begin
        shreg <= {bus.sin, shreg[DATA_W-1:1]};
        cnt   <= cnt + CNT_W'(1);
      end
      if (par_take) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
        perr_q  <= bus.sin ^ exp_par;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.busy       = (state == SHIFT) || (state == PARITY);

`ifdef S2P_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of parity errors, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (perr_q && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_s2p_parity_rx.sv
// tb/tb_s2p_parity_rx.sv - self-checking bench for s2p_parity_rx (even and odd instances)
module tb_s2p_parity_rx;

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         stall;
    logic       exp_e;
    logic       exp_o;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       perr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q_e[$];
  exp_t q_o[$];
  vec_t vecs[8];

  s2p_parity_rx_if #(.DATA_W(8)) bus_e ();
  s2p_parity_rx_if #(.DATA_W(8)) bus_o ();

  s2p_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut_e (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_e.slave)
  );

  s2p_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_o (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_o.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic f);
    bus_e.sin = s; bus_e.sin_valid = v; bus_e.sof = f;
    bus_o.sin = s; bus_o.sin_valid = v; bus_o.sof = f;
  endtask

  // Advance one clock, sample #1 after the edge and score any produced word.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus_e.data_valid) begin
      if (q_e.size() == 0) begin
        check("spurious_valid_even", 1, 0);
      end else begin
        e = q_e.pop_front();
        check("data_even", bus_e.data_out, e.data);
        check("perr_even", bus_e.parity_err, e.perr);
      end
    end else if (bus_e.parity_err) begin
      check("perr_without_valid_even", 1, 0);
    end
    if (bus_o.data_valid) begin
      if (q_o.size() == 0) begin
        check("spurious_valid_odd", 1, 0);
      end else begin
        e = q_o.pop_front();
        check("data_odd", bus_o.data_out, e.data);
        check("perr_odd", bus_o.parity_err, e.perr);
      end
    end else if (bus_o.parity_err) begin
      check("perr_without_valid_odd", 1, 0);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      drive(d[i], 1'b1, i == 0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input int stall,
                            input logic ee, input logic eo);
    for (int i = 0; i < 8; i++) begin
      drive(d[i], 1'b1, i == 0);
      tick();
      check("busy_in_frame", bus_e.busy, 1);
      drive(1'b0, 1'b0, 1'b0);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("busy_in_stall", bus_e.busy, 1);
      end
    end
    drive(p, 1'b1, 1'b0);
    q_e.push_back('{d, ee});
    q_o.push_back('{d, eo});
    tick();
    check("busy_done", bus_e.busy, 0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{8'hA5, 1'b1, 0, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 3, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 0, 1'b0, 1'b1};
    vecs[5] = '{8'h96, 1'b0, 0, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b0, 0, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 1'b1, 1, 1'b0, 1'b1};

    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_data_out", bus_e.data_out, 0);
    check("reset_valid", bus_e.data_valid, 0);
    check("reset_perr", bus_e.parity_err, 0);
    check("reset_busy", bus_e.busy, 0);
`ifdef S2P_ERR_CNT_EN
    check("reset_err_count", bus_e.err_count, 0);
`endif

    // IDLE ignores sin_valid without sof, and sof without sin_valid.
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("idle_no_sof_busy", bus_e.busy, 0);
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check("sof_no_valid_busy", bus_e.busy, 0);
    idle(1);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stall, vecs[i].exp_e, vecs[i].exp_o);
      idle(2);
    end
    check("data_held_after_idle", bus_e.data_out, 8'h7F);

    // Abort after 4 bits, then two back-to-back frames with no dead cycle.
    send_bits(8'hFF, 4);
    send_frame(8'h01, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'h80, 1'b1, 0, 1'b0, 1'b1);
    idle(3);
    check("data_after_b2b", bus_e.data_out, 8'h80);

    // Abort that leaves data_out untouched.
    send_bits(8'h33, 6);
    idle(12);
    check("data_kept_after_abort", bus_e.data_out, 8'h80);
    send_frame(8'h33, 1'b1, 0, 1'b1, 1'b0);
    idle(2);

    // Reset mid-frame discards the partial frame.
    send_bits(8'hFF, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_data_out", bus_e.data_out, 0);
    check("midreset_busy", bus_e.busy, 0);
    check("midreset_valid", bus_e.data_valid, 0);
    idle(12);
    send_frame(8'h5A, 1'b0, 0, 1'b0, 1'b1);
    idle(2);
    check("data_after_midreset", bus_e.data_out, 8'h5A);

`ifdef S2P_ERR_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("errcnt_reset", bus_e.err_count, 0);
    for (int n = 1; n <= 260; n++) begin
      send_frame(8'h00, 1'b1, 0, 1'b1, 1'b0);
      idle(1);
      check("errcnt_step", bus_e.err_count, (n > 255) ? 255 : n);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("errcnt_cleared", bus_e.err_count, 0);
`endif

    check("queue_even_drained", q_e.size(), 0);
    check("queue_odd_drained", q_o.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
